inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, at least 2).
REQ-002 SHALL have parameter RESET_PC, default 32'hbfc00000, giving the first fetch address after reset.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port inst_sram_en, output, 1 bit: read request to instruction SRAM this cycle.
REQ-007 Port inst_sram_addr, output, 32 bits: byte address of the request.
REQ-008 Port inst_sram_wen, output, 4 bits: constant 4'b0.
REQ-009 Port inst_sram_wdata, output, 32 bits: constant 32'b0.
REQ-010 Port inst_sram_rdata, input, 32 bits: read data, valid exactly one cycle after a request.
REQ-011 Port br_redirect, input, 1 bit: redirect from decode/execute (taken branch, jump, jr).
REQ-012 Port br_target, input, 32 bits: new fetch address, sampled when br_redirect=1.
REQ-013 Port ds_allowin, input, 1 bit: decode stage accepts an instruction this cycle.
REQ-014 Port fs_to_ds_valid, output, 1 bit: head entry is valid.
REQ-015 Port fs_pc, output, 32 bits: PC of the head entry.
REQ-016 Port fs_inst, output, 32 bits: instruction of the head entry.
REQ-017 Port fs_adel, output, 1 bit: head entry carries an instruction-fetch address error.

Function
REQ-018 SHALL hold fetch_pc, a FIFO of {pc, inst, adel} entries with count, a pending bit and pending_pc (one outstanding SRAM read maximum).
REQ-019 SHALL issue a request (inst_sram_en=1, inst_sram_addr=fetch_pc) when count+pending < DEPTH, br_redirect=0, halted=0 and fetch_pc[1:0]==2'b00.
REQ-020 On an issue, SHALL set pending=1, pending_pc=fetch_pc and fetch_pc=fetch_pc+4, with 32-bit wrap-around and no carry out.
REQ-021 When pending=1 and br_redirect=0, SHALL enqueue {pending_pc, inst_sram_rdata, 0} and clear pending unless a new request is issued the same cycle.
REQ-022 A response is not bypassed to the outputs, so the minimum latency from request to fs_to_ds_valid is 2 cycles.
REQ-023 SHALL drive fs_to_ds_valid=(count!=0), and fs_pc/fs_inst/fs_adel from the head entry.
REQ-024 Pop SHALL occur when fs_to_ds_valid && ds_allowin.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged.
REQ-026 Steady-state throughput SHALL be 1 instruction/cycle when ds_allowin is held at 1.
REQ-027 When br_redirect=1, SHALL:
  - clear the FIFO (count=0, pointers reset);
  - discard the pending response, even if it would return that cycle or the next;
  - clear halted;
  - load fetch_pc=br_target;
  - issue no request that cycle.
REQ-028 Redirect SHALL take priority over a simultaneous push or pop; if a pop coincides, the head is still consumed by decode that cycle.
REQ-029 If fetch_pc[1:0]!=0 and all issue conditions other than alignment hold, SHALL make no SRAM access.
REQ-030 In the case of REQ-029, SHALL enqueue {fetch_pc, 32'b0, 1} once pending=0, set halted=1, and stop fetching until br_redirect.
REQ-031 When the FIFO is full (count==DEPTH), SHALL never overwrite an entry; the count+pending bound guarantees a slot for every outstanding response.
REQ-032 SHALL allow fs_pc/fs_inst to be arbitrary when fs_to_ds_valid=0.

Reset
REQ-033 While rst=1, SHALL force fetch_pc=RESET_PC, count=0, pointers=0, pending=0, halted=0, inst_sram_en=0 and fs_to_ds_valid=0, asynchronously.
REQ-034 In the first clock edge after rst deasserts, SHALL issue inst_sram_addr=RESET_PC.
REQ-035 Reset during an outstanding read SHALL drop that response.

Verification
REQ-036 Reset release with ds_allowin=1 and SRAM returning addr-based data: expect requests at bfc00000, bfc00004, ... on consecutive cycles and fs_to_ds_valid rising 2 cycles after the first request.
REQ-037 Hold ds_allowin=0: expect exactly DEPTH=4 entries (pcs bfc00000..bfc0000c), then inst_sram_en=0 with no lost or duplicate entries. Raise ds_allowin: expect pops in order and fetch resuming at bfc00010.
REQ-038 Assert br_redirect with br_target=bfc00100 while count=2 and pending=1: expect next fs_to_ds_valid entry pc=bfc00100, with no stale pc delivered.
REQ-039 Assert br_redirect with br_target=bfc00102: expect no SRAM request, then one entry {bfc00102, 0, adel=1}, then inst_sram_en held at 0. A subsequent redirect to bfc00200 resumes fetching.
REQ-040 Assert rst asynchronously mid-stream with pending=1: expect fs_to_ds_valid=0 immediately and the first post-reset request at bfc00000.
REQ-041 Start from fetch_pc=fffffffc via redirect: expect the next request address to be 00000000.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch-queue signal bundle: instruction SRAM port, redirect input, decode handoff
interface inst_fetch_queue_if;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    logic        br_redirect;
    logic [31:0] br_target;

    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adel;

    modport master (
        output inst_sram_en,
        output inst_sram_addr,
        output inst_sram_wen,
        output inst_sram_wdata,
        input  inst_sram_rdata,
        input  br_redirect,
        input  br_target,
        input  ds_allowin,
        output fs_to_ds_valid,
        output fs_pc,
        output fs_inst,
        output fs_adel
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_addr,
        input  inst_sram_wen,
        input  inst_sram_wdata,
        output inst_sram_rdata,
        output br_redirect,
        output br_target,
        output ds_allowin,
        input  fs_to_ds_valid,
        input  fs_pc,
        input  fs_inst,
        input  fs_adel
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch with one outstanding SRAM read and a DEPTH-entry queue to decode
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [31:0]    fetch_pc;
    logic           pending;
    logic [31:0]    pending_pc;
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;

    logic [31:0]    pc_mem   [DEPTH];
    logic [31:0]    inst_mem [DEPTH];
    logic           adel_mem [DEPTH];

    logic [CW-1:0]  occupancy;
    logic           slot_free;
    logic           aligned;
    logic           issue;
    logic           adel_push;
    logic           resp_push;
    logic           push;
    logic           pop;
    logic [31:0]    push_pc;
    logic [31:0]    push_inst;

    // Outstanding read reserves its slot up front, so a response always has room.
    assign occupancy = count + CW'(pending);
    assign slot_free = occupancy < CW'(DEPTH);
    assign aligned   = (fetch_pc[1:0] == 2'b00);
    assign resp_push = pending && !bus.br_redirect;
    assign push      = resp_push || adel_push;
    assign pop       = (count != '0) && bus.ds_allowin;
    assign push_pc   = adel_push ? fetch_pc : pending_pc;
    assign push_inst = adel_push ? 32'h0 : bus.inst_sram_rdata;

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        adel_push = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!bus.br_redirect && slot_free) begin
                    if (aligned) begin
                        issue = 1'b1;
                    end else if (!pending) begin
                        // Misaligned PC: report once through the queue, then park.
                        adel_push = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (bus.br_redirect) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= 32'h0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
        end else if (bus.br_redirect) begin
            // Any in-flight response belongs to the squashed path and is dropped.
            fetch_pc <= bus.br_target;
            pending  <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + 32'd4;
            end
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]   <= push_pc;
            inst_mem[wptr] <= push_inst;
            adel_mem[wptr] <= adel_push;
        end
    end

    assign bus.inst_sram_en    = issue && !rst;
    assign bus.inst_sram_addr  = fetch_pc;
    assign bus.inst_sram_wen   = 4'b0;
    assign bus.inst_sram_wdata = 32'b0;

    assign bus.fs_to_ds_valid  = (count != '0);
    assign bus.fs_pc           = pc_mem[rptr];
    assign bus.fs_inst         = inst_mem[rptr];
    assign bus.fs_adel         = adel_mem[rptr];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   n_req;
    logic [31:0] req_addr [8];

    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hbfc00000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM: data for a request appears in the following cycle, derived from the address.
    always @(posedge clk) begin
        if (bus.inst_sram_en) bus.inst_sram_rdata <= ~bus.inst_sram_addr;
        else                  bus.inst_sram_rdata <= 32'hdeadbeef;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        check("rst_en",    {31'b0, bus.inst_sram_en},   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst               = 1'b1;
        bus.br_redirect   = 1'b0;
        bus.br_target     = 32'h0;
        bus.ds_allowin    = 1'b1;
        bus.inst_sram_rdata = 32'h0;

        // Reset release, streaming
        do_reset();
        check("wen_const",   {28'b0, bus.inst_sram_wen}, 32'd0);
        check("wdata_const", bus.inst_sram_wdata, 32'd0);
        check("s_en0",   {31'b0, bus.inst_sram_en}, 32'd1);
        check("s_addr0", bus.inst_sram_addr, 32'hbfc00000);
        check("s_val0",  {31'b0, bus.fs_to_ds_valid}, 32'd0);
        cyc();
        check("s_addr1", bus.inst_sram_addr, 32'hbfc00004);
        check("s_val1",  {31'b0, bus.fs_to_ds_valid}, 32'd0);
        cyc();
        check("s_addr2", bus.inst_sram_addr, 32'hbfc00008);
        check("s_val2",  {31'b0, bus.fs_to_ds_valid}, 32'd1);
        check("s_pc2",   bus.fs_pc, 32'hbfc00000);
        check("s_inst2", bus.fs_inst, ~32'hbfc00000);
        cyc();
        check("s_pc3",   bus.fs_pc, 32'hbfc00004);
        check("s_inst3", bus.fs_inst, ~32'hbfc00004);

        // Back-pressure: queue fills to DEPTH then stops fetching
        bus.ds_allowin = 1'b0;
        do_reset();
        n_req = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.inst_sram_en) begin
                if (n_req < 8) req_addr[n_req] = bus.inst_sram_addr;
                n_req++;
            end
            cyc();
        end
        check("f_nreq", n_req, 32'd4);
        for (int i = 0; i < 4; i++) check("f_addr", req_addr[i], 32'hbfc00000 + 32'(4 * i));
        check("f_en",  {31'b0, bus.inst_sram_en}, 32'd0);
        check("f_val", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        check("f_pc0", bus.fs_pc, 32'hbfc00000);
        bus.ds_allowin = 1'b1;
        #1;
        check("f_en_full", {31'b0, bus.inst_sram_en}, 32'd0);
        cyc();
        check("f_resume_en",   {31'b0, bus.inst_sram_en}, 32'd1);
        check("f_resume_addr", bus.inst_sram_addr, 32'hbfc00010);
        check("f_pc1", bus.fs_pc, 32'hbfc00004);
        cyc();
        check("f_pc2", bus.fs_pc, 32'hbfc00008);
        cyc();
        check("f_pc3", bus.fs_pc, 32'hbfc0000c);
        cyc();
        check("f_pc4",   bus.fs_pc, 32'hbfc00010);
        check("f_inst4", bus.fs_inst, ~32'hbfc00010);

        // Redirect with count=2, pending=1
        bus.ds_allowin = 1'b0;
        do_reset();
        repeat (3) cyc();
        bus.br_redirect = 1'b1;
        bus.br_target   = 32'hbfc00100;
        #1;
        check("r_en_redir", {31'b0, bus.inst_sram_en}, 32'd0);
        cyc();
        bus.br_redirect = 1'b0;
        #1;
        check("r_val0", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        check("r_addr0", bus.inst_sram_addr, 32'hbfc00100);
        check("r_en0",  {31'b0, bus.inst_sram_en}, 32'd1);
        cyc();
        check("r_val1", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        cyc();
        check("r_val2",  {31'b0, bus.fs_to_ds_valid}, 32'd1);
        check("r_pc2",   bus.fs_pc, 32'hbfc00100);
        check("r_inst2", bus.fs_inst, ~32'hbfc00100);
        check("r_adel2", {31'b0, bus.fs_adel}, 32'd0);

        // Misaligned redirect (coincides with a pop): one adel entry, then halt
        bus.br_redirect = 1'b1;
        bus.br_target   = 32'hbfc00102;
        bus.ds_allowin  = 1'b1;
        #1;
        cyc();
        bus.br_redirect = 1'b0;
        #1;
        check("a_en0",  {31'b0, bus.inst_sram_en}, 32'd0);
        check("a_val0", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        cyc();
        check("a_val1",  {31'b0, bus.fs_to_ds_valid}, 32'd1);
        check("a_pc1",   bus.fs_pc, 32'hbfc00102);
        check("a_inst1", bus.fs_inst, 32'h0);
        check("a_adel1", {31'b0, bus.fs_adel}, 32'd1);
        check("a_en1",   {31'b0, bus.inst_sram_en}, 32'd0);
        cyc();
        check("a_val2", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        check("a_en2",  {31'b0, bus.inst_sram_en}, 32'd0);
        cyc();
        check("a_en3",  {31'b0, bus.inst_sram_en}, 32'd0);
        bus.br_redirect = 1'b1;
        bus.br_target   = 32'hbfc00200;
        #1;
        cyc();
        bus.br_redirect = 1'b0;
        #1;
        check("a_res_en",   {31'b0, bus.inst_sram_en}, 32'd1);
        check("a_res_addr", bus.inst_sram_addr, 32'hbfc00200);
        cyc();
        cyc();
        check("a_res_pc",   bus.fs_pc, 32'hbfc00200);
        check("a_res_adel", {31'b0, bus.fs_adel}, 32'd0);

        // Asynchronous reset mid-stream with a read outstanding
        #2;
        rst = 1'b1;
        #1;
        check("x_val", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        check("x_en",  {31'b0, bus.inst_sram_en}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("x_addr", bus.inst_sram_addr, 32'hbfc00000);
        check("x_en1",  {31'b0, bus.inst_sram_en}, 32'd1);
        cyc();
        check("x_val1", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        cyc();
        check("x_val2", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        check("x_pc2",  bus.fs_pc, 32'hbfc00000);

        // PC wrap-around
        bus.br_redirect = 1'b1;
        bus.br_target   = 32'hfffffffc;
        #1;
        check("w_en_redir", {31'b0, bus.inst_sram_en}, 32'd0);
        cyc();
        bus.br_redirect = 1'b0;
        #1;
        check("w_addr0", bus.inst_sram_addr, 32'hfffffffc);
        cyc();
        check("w_addr1", bus.inst_sram_addr, 32'h00000000);
        check("w_en1",   {31'b0, bus.inst_sram_en}, 32'd1);
        cyc();
        check("w_pc0",   bus.fs_pc, 32'hfffffffc);
        cyc();
        check("w_pc1",   bus.fs_pc, 32'h00000000);
        check("w_inst1", bus.fs_inst, 32'hffffffff);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
